spi_slave_bridge: RTL and testbench

SPI_SLAVE_BRIDGE -- requirements
Module: spi_slave_bridge

---
 rtl/spi_slave_bridge_if.sv | 15 +
 rtl/spi_slave_bridge.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_bridge.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_bridge_if.sv
// Memory-side bus of the SPI slave bridge: write strobe, read request, read return.
interface spi_slave_bridge_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic              o_wr;
    logic              o_rd;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;

    modport slave  (output o_wr, o_rd, o_addr, o_wdata, input  i_rdata, i_rvalid);
    modport master (input  o_wr, o_rd, o_addr, o_wdata, output i_rdata, i_rvalid);
endinterface

// File: rtl/spi_slave_bridge.sv
// SPI slave to memory bridge: 16-bit header (mode + start address), then streamed
// write or read words with auto-incrementing address. All SPI pins are oversampled.
module spi_slave_bridge #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_ssn,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_miso_oe,
    output logic o_active,
    output logic o_underrun,
    output logic o_cmd_err,
    spi_slave_bridge_if.slave mem
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_SKIP = 3'd4;
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic [2:0]        sclk_q, ssn_q;
    logic [1:0]        mosi_q;
    logic              armed_q;
    logic [2:0]        state_q, state_d;
    logic [3:0]        bit_cnt_q;
    logic [14:0]       rx_q;
    logic [DATA_W-1:0] tx_q, rbuf_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q, rd_q;
    logic              rd_pend_q, rbuf_vld_q, load_pend_q;
    logic              underrun_q, cmd_err_q;

    logic        sclk_rise, sclk_fall, lead_e, trail_e, in_xfer;
    logic        sample_e, shift_e, ssn_fall, hdr_done, word_done;
    logic [15:0] rx_nxt;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign lead_e    = CPOL ? sclk_fall : sclk_rise;
    assign trail_e   = CPOL ? sclk_rise : sclk_fall;
    assign in_xfer   = (state_q != S_IDLE) & ~ssn_q[1];
    assign sample_e  = (CPHA ? trail_e : lead_e) & in_xfer;
    assign shift_e   = (CPHA ? lead_e : trail_e) & in_xfer;
    // armed_q blocks a start until SSN has been seen high since reset
    assign ssn_fall  = ~ssn_q[1] & ssn_q[2] & armed_q;
    assign rx_nxt    = {rx_q, mosi_q[1]};
    assign hdr_done  = sample_e & (state_q == S_HDR) & (bit_cnt_q == 4'd15);
    assign word_done = sample_e & ((state_q == S_WR) | (state_q == S_RD)) & (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d = state_q;
        if (ssn_q[1]) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (ssn_fall) state_d = S_HDR;
        end else if (hdr_done) begin
            case (rx_nxt[15:14])
                2'b10:   state_d = S_WR;
                2'b01:   state_d = S_RD;
                default: state_d = S_SKIP;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            sclk_q      <= '0;
            ssn_q       <= '0;
            mosi_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rbuf_q      <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            rbuf_vld_q  <= 1'b0;
            load_pend_q <= 1'b0;
            underrun_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], i_sclk};
            ssn_q   <= {ssn_q[1:0], i_ssn};
            mosi_q  <= {mosi_q[0], i_mosi};
            state_q <= state_d;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            if (ssn_q[1]) armed_q <= 1'b1;
            if (wr_q | rd_q) addr_q <= addr_q + ADDR_W'(1);
            if (ssn_fall) begin
                bit_cnt_q  <= '0;
                underrun_q <= 1'b0;
                cmd_err_q  <= 1'b0;
            end
            if (sample_e) begin
                rx_q      <= rx_nxt[14:0];
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (hdr_done) begin
                    bit_cnt_q <= '0;
                    addr_q    <= rx_nxt[ADDR_W-1:0];
                    case (rx_nxt[15:14])
                        2'b10: ;
                        2'b01: begin
                            rd_q        <= 1'b1;
                            rd_pend_q   <= 1'b1;
                            load_pend_q <= 1'b1;
                        end
                        default: cmd_err_q <= 1'b1;
                    endcase
                end else if (word_done) begin
                    bit_cnt_q <= '0;
                    if (state_q == S_WR) begin
                        wr_q    <= 1'b1;
                        wdata_q <= rx_nxt[DATA_W-1:0];
                    end else begin
                        rd_q        <= 1'b1;
                        rd_pend_q   <= 1'b1;
                        load_pend_q <= 1'b1;
                    end
                end
            end
            if (mem.i_rvalid && rd_pend_q) begin
                rbuf_q     <= mem.i_rdata;
                rbuf_vld_q <= 1'b1;
                rd_pend_q  <= 1'b0;
            end
            // First shift edge after a read request loads the returned word, or zero if late
            if (shift_e && state_q == S_RD) begin
                if (load_pend_q) begin
                    tx_q        <= rbuf_vld_q ? rbuf_q : '0;
                    underrun_q  <= underrun_q | ~rbuf_vld_q;
                    rbuf_vld_q  <= 1'b0;
                    rd_pend_q   <= 1'b0;
                    load_pend_q <= 1'b0;
                end else begin
                    tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            if (ssn_q[1]) begin
                bit_cnt_q   <= '0;
                rd_pend_q   <= 1'b0;
                rbuf_vld_q  <= 1'b0;
                load_pend_q <= 1'b0;
            end
        end
    end

    assign o_miso      = (state_q == S_RD) ? tx_q[DATA_W-1] : 1'b0;
    assign o_miso_oe   = ~ssn_q[1] & armed_q;
    assign o_active    = (state_q != S_IDLE);
    assign o_underrun  = underrun_q;
    assign o_cmd_err   = cmd_err_q;
    assign mem.o_wr    = wr_q;
    assign mem.o_rd    = rd_q;
    assign mem.o_addr  = addr_q;
    assign mem.o_wdata = wdata_q;
endmodule

// File: tb/tb_spi_slave_bridge.sv
// Bench for spi_slave_bridge: four instances cover all SPI modes, 16-bit data and a
// 4-bit address; strobes are checked against an expected-event queue by a monitor.
module tb_spi_slave_bridge;
    localparam int HP = 16;

    logic clk, rst;
    logic [3:0] sclk, ssn, mosi;
    logic [3:0] rvalid_v;
    logic [3:0][15:0] rdata_v;
    wire  [3:0] miso, oe, active, uf, ce, wr_v, rd_v;
    wire  [3:0][15:0] addr_v, wdata_v;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DW = (g == 3) ? 16 : 8;
        localparam int AW = (g == 2) ? 4 : 14;
        spi_slave_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        spi_slave_bridge #(.DATA_W(DW), .ADDR_W(AW), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
            .i_sys_clk (clk),
            .i_rst     (rst),
            .i_sclk    (sclk[g]),
            .i_ssn     (ssn[g]),
            .i_mosi    (mosi[g]),
            .o_miso    (miso[g]),
            .o_miso_oe (oe[g]),
            .o_active  (active[g]),
            .o_underrun(uf[g]),
            .o_cmd_err (ce[g]),
            .mem       (bus.slave)
        );
        assign bus.i_rdata  = rdata_v[g][DW-1:0];
        assign bus.i_rvalid = rvalid_v[g];
        assign wr_v[g]      = bus.o_wr;
        assign rd_v[g]      = bus.o_rd;
        assign addr_v[g]    = 16'(bus.o_addr);
        assign wdata_v[g]   = 16'(bus.o_wdata);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  dut;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    string       pq_nm[$];
    logic [31:0] pq_got[$];
    logic [31:0] pq_exp[$];
    logic [15:0] rd_data_q[$];
    bit          withhold;
    int          checks, errors;

    task automatic expect_ev(input int d, input bit r, input logic [15:0] a, input logic [15:0] w);
        ev_t e;
        e.dut = 2'(d); e.rd = r; e.addr = a; e.data = w;
        exp_q.push_back(e);
    endtask

    task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
        pq_nm.push_back(nm); pq_got.push_back(got); pq_exp.push_back(exp);
    endtask

    // Monitor: strobes against the expected-event queue, plus posted point checks
    initial begin
        ev_t e;
        string nm;
        logic [31:0] g, x;
        checks = 0; errors = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (wr_v[k] || rd_v[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL strobe: dut%0d unexpected wr=%0b rd=%0b addr=%h data=%h",
                                 k, wr_v[k], rd_v[k], addr_v[k], wdata_v[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut != 2'(k) || e.rd != rd_v[k] || e.addr != addr_v[k] ||
                            (!e.rd && e.data != wdata_v[k])) begin
                            errors++;
                            $display("FAIL strobe: got dut%0d rd=%0b addr=%h data=%h, expected dut%0d rd=%0b addr=%h data=%h",
                                     k, rd_v[k], addr_v[k], wdata_v[k], e.dut, e.rd, e.addr, e.data);
                        end
                    end
                end
            end
            while (pq_nm.size() > 0) begin
                nm = pq_nm.pop_front(); g = pq_got.pop_front(); x = pq_exp.pop_front();
                checks++;
                if (g !== x) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", nm, g, x);
                end
            end
        end
    end

    // Memory model: returns rvalid two cycles after each o_rd unless withheld
    initial begin
        int rcnt[4];
        logic [15:0] rdat[4];
        for (int k = 0; k < 4; k++) begin rcnt[k] = 0; rdat[k] = '0; end
        rvalid_v = '0; rdata_v = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                rvalid_v[k] = (rcnt[k] == 1);
                rdata_v[k]  = (rcnt[k] == 1) ? rdat[k] : 16'h0;
                if (rcnt[k] > 0) rcnt[k]--;
                if (rd_v[k] && !withhold) begin
                    rcnt[k] = 2;
                    rdat[k] = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 16'hDEAD;
                end
            end
        end
    end

    task automatic spi_bits(input int d, input int n, input logic [47:0] tx, output logic [47:0] rx);
        logic cpol, cpha;
        cpol = (d >= 2);
        cpha = (d % 2 == 1);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi[d] = tx[i];
                repeat (HP) @(posedge clk);
                sclk[d] = ~cpol; rx[i] = miso[d];
                repeat (HP) @(posedge clk);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol; mosi[d] = tx[i];
                repeat (HP) @(posedge clk);
                sclk[d] = cpol; rx[i] = miso[d];
                repeat (HP) @(posedge clk);
            end
        end
    endtask

    task automatic xact(input int d, input int n, input logic [47:0] tx, output logic [47:0] rx);
        ssn[d] = 1'b0;
        repeat (HP) @(posedge clk);
        @(negedge clk);
        post("selected", 32'({active[d], oe[d], uf[d], ce[d]}), 32'b1100);
        spi_bits(d, n, tx, rx);
        repeat (HP) @(posedge clk);
        ssn[d] = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        post("deselected", 32'({active[d], oe[d]}), 32'b00);
    endtask

    initial begin
        logic [47:0] rx;
        withhold = 1'b0;
        rst = 1'b1; ssn = 4'hF; mosi = '0; sclk = 4'b1100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        post("reset_state", 32'({wr_v[0], rd_v[0], miso[0], oe[0], active[0], uf[0], ce[0]}), 32'h0);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Basic write in modes 0, 1, 2 (8-bit); mode 2 instance has a 4-bit address
        expect_ev(0, 0, 16'h010, 16'hA5); expect_ev(0, 0, 16'h011, 16'h3C);
        xact(0, 32, 48'({16'h8010, 8'hA5, 8'h3C}), rx);
        expect_ev(1, 0, 16'h010, 16'hA5); expect_ev(1, 0, 16'h011, 16'h3C);
        xact(1, 32, 48'({16'h8010, 8'hA5, 8'h3C}), rx);
        expect_ev(2, 0, 16'h0, 16'hA5); expect_ev(2, 0, 16'h1, 16'h3C);
        xact(2, 32, 48'({16'h8010, 8'hA5, 8'h3C}), rx);
        // Mode 3, 16-bit word
        expect_ev(3, 0, 16'h0000, 16'hBEEF);
        xact(3, 32, 48'({16'h8000, 16'hBEEF}), rx);
        // Address wrap with 4-bit address
        expect_ev(2, 0, 16'hF, 16'h12); expect_ev(2, 0, 16'h0, 16'h34);
        xact(2, 32, 48'({16'h800F, 8'h12, 8'h34}), rx);

        // Read with timely data, including the prefetch after the last word
        rd_data_q = '{16'h5A, 16'hC3, 16'hFF};
        expect_ev(0, 1, 16'h020, 16'h0); expect_ev(0, 1, 16'h021, 16'h0); expect_ev(0, 1, 16'h022, 16'h0);
        xact(0, 32, 48'({16'h4020, 16'h0000}), rx);
        post("rd_miso", rx[31:0], 32'h00005AC3);
        post("rd_underrun", 32'(uf[0]), 32'h0);

        // Read with data withheld: zero word, sticky underrun
        withhold = 1'b1;
        expect_ev(0, 1, 16'h030, 16'h0); expect_ev(0, 1, 16'h031, 16'h0);
        xact(0, 24, 48'({16'h4030, 8'h00}), rx);
        post("late_miso", rx[23:0], 32'h0);
        post("late_underrun", 32'(uf[0]), 32'h1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        post("underrun_hold", 32'(uf[0]), 32'h1);
        withhold = 1'b0;

        // Partial write word is discarded (selected check also sees underrun cleared)
        xact(0, 21, 48'({16'h8050, 5'b10101}), rx);
        // Unsupported mode: cmd_err, no strobes, MISO quiet
        xact(0, 24, 48'({16'hC000, 8'hFF}), rx);
        post("skip_miso", rx[23:0], 32'h0);
        post("cmd_err", 32'(ce[0]), 32'h1);
        // Next transaction clears cmd_err at selection and still writes normally
        expect_ev(0, 0, 16'h080, 16'h99);
        xact(0, 24, 48'({16'h8080, 8'h99}), rx);

        // Reset mid-transfer: everything cleared, no activity until SSN high then low
        ssn[1] = 1'b0;
        repeat (HP) @(posedge clk);
        spi_bits(1, 20, 48'({16'h8060, 4'hA}), rx);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        post("mid_reset", 32'({wr_v[1], rd_v[1], miso[1], oe[1], active[1], uf[1], ce[1]}), 32'h0);
        rst = 1'b0;
        spi_bits(1, 8, 48'(8'hFF), rx);
        @(negedge clk);
        post("post_reset_idle", 32'({active[1], oe[1]}), 32'h0);
        ssn[1] = 1'b1;
        repeat (8) @(posedge clk);
        expect_ev(1, 0, 16'h070, 16'h77);
        xact(1, 24, 48'({16'h8070, 8'h77}), rx);

        repeat (20) @(posedge clk);
        @(negedge clk);
        post("missing_strobes", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
